// File: rtl/csr_serial_tx_if.sv
// CSR bus bundle between the CSR bridge (master) and a CSR responder (slave).
// csr_do is the responder's registered read data, OR-ed into the bridge's read path.
interface csr_serial_tx_if;
    logic [13:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_di;
    logic [31:0] csr_do;

    modport master (
        output csr_a,
        output csr_we,
        output csr_di,
        input  csr_do
    );

    modport slave (
        input  csr_a,
        input  csr_we,
        input  csr_di,
        output csr_do
    );
endinterface

// File: rtl/csr_serial_tx.sv
// CSR-mapped 8N1 serial transmitter: TX FIFO, programmable baud divisor,
// status/interrupt readback on the CSR read path.
module csr_serial_tx #(
    parameter logic [3:0]  csr_addr        = 4'h4,
    parameter int unsigned FIFO_DEPTH_LOG2 = 4,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd434
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    csr_serial_tx_if.slave bus,
    output logic           tx,
    output logic           irq
);

    localparam int unsigned Depth = 2 ** FIFO_DEPTH_LOG2;
    localparam int unsigned PtrW  = FIFO_DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    // CSR decode
    logic       sel;
    logic [9:0] idx;
    logic       wr;
    logic       push_req;
    logic       div_wr;
    logic       status_wr;
    logic       ctrl_wr;
    logic       flush;
    logic       unused_di;

    assign sel       = (bus.csr_a[13:10] == csr_addr);
    assign idx       = bus.csr_a[9:0];
    assign wr        = sel & bus.csr_we;
    assign push_req  = wr & (idx == 10'd0);
    assign div_wr    = wr & (idx == 10'd1);
    assign status_wr = wr & (idx == 10'd2);
    assign ctrl_wr   = wr & (idx == 10'd3);
    assign flush     = ctrl_wr & bus.csr_di[2];
    assign unused_di = ^bus.csr_di[31:16];

    // Registers
    logic [7:0]      mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [15:0]     div_q;
    logic            tx_en_q;
    logic            irq_en_q;
    logic            overflow_q;
    state_e          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            tx_q, tx_d;
    logic            irq_q, irq_d;
    logic [31:0]     csr_do_q;

    // FIFO status
    logic [PtrW-1:0] level;
    logic            full;
    logic            empty;
    logic            pop;
    logic            push_ok;
    logic            overflow_set;

    assign level   = wr_ptr_q - rd_ptr_q;
    assign full    = (level == PtrW'(Depth));
    assign empty   = (level == '0);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok      = push_req & ~flush & (~full | pop);
    assign overflow_set = push_req & ~flush & full & ~pop;
    assign wr_ptr_d     = wr_ptr_q + PtrW'(push_ok);
    assign rd_ptr_d     = flush ? wr_ptr_q : rd_ptr_q + PtrW'(pop);

    // Divisor values 0 and 1 both mean one cycle per bit
    logic [15:0] eff_div;
    logic [15:0] reload;
    logic        bit_end;
    logic        can_start;
    logic        busy;

    assign eff_div   = (div_q < 16'd2) ? 16'd1 : div_q;
    assign reload    = eff_div - 16'd1;
    assign bit_end   = (cnt_q == 16'd0);
    assign can_start = tx_en_q & ~empty;
    assign busy      = (state_q != StIdle);

    // Transmit FSM next state
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        pop       = 1'b0;
        case (state_q)
            StIdle: begin
                if (can_start) begin
                    pop     = 1'b1;
                    shreg_d = mem_q[rd_ptr_q[FIFO_DEPTH_LOG2-1:0]];
                    cnt_d   = reload;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d   = StData;
                    bit_idx_d = 3'd0;
                    cnt_d     = reload;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StData: begin
                if (bit_end) begin
                    cnt_d = reload;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (can_start) begin
                        pop     = 1'b1;
                        shreg_d = mem_q[rd_ptr_q[FIFO_DEPTH_LOG2-1:0]];
                        cnt_d   = reload;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line level follows the next state so tx is a clean flop output
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shreg_d[bit_idx_d];
            default: tx_d = 1'b1;
        endcase
    end

    assign irq_d = irq_en_q & empty & ~busy;

    // Read mux
    logic [31:0] rdata;

    always_comb begin
        rdata = '0;
        case (idx)
            10'd1: rdata[15:0] = div_q;
            10'd2: begin
                rdata[0]         = busy;
                rdata[1]         = full;
                rdata[2]         = empty;
                rdata[3]         = overflow_q;
                rdata[8 +: PtrW] = level;
            end
            10'd3: rdata[1:0] = {irq_en_q, tx_en_q};
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            div_q      <= DEFAULT_DIVISOR;
            tx_en_q    <= 1'b0;
            irq_en_q   <= 1'b0;
            overflow_q <= 1'b0;
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
            irq_q      <= 1'b0;
            csr_do_q   <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q[FIFO_DEPTH_LOG2-1:0]] <= bus.csr_di[7:0];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (div_wr) begin
                div_q <= bus.csr_di[15:0];
            end
            if (ctrl_wr) begin
                tx_en_q  <= bus.csr_di[0];
                irq_en_q <= bus.csr_di[1];
            end
            if (overflow_set) begin
                overflow_q <= 1'b1;
            end else if (status_wr && bus.csr_di[3]) begin
                overflow_q <= 1'b0;
            end
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
            irq_q     <= irq_d;
            csr_do_q  <= sel ? rdata : '0;
        end
    end

    assign bus.csr_do = csr_do_q;
    assign tx         = tx_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_csr_serial_tx.sv
// Self-checking bench for csr_serial_tx: randomized traffic against a queue-based
// FIFO model and a frame-level picture of the expected serial line.
module tb_csr_serial_tx;

    localparam logic [3:0] Page = 4'h4;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    logic tx;
    logic irq;

    csr_serial_tx_if bus ();

    csr_serial_tx dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus),
        .tx       (tx),
        .irq      (irq)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: bytes accepted by the FIFO, sticky overflow flag
    logic [7:0] fifo_q[$];
    logic       model_ovf = 1'b0;

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s = '0;
        s[1] = (fifo_q.size() == 16);
        s[2] = (fifo_q.size() == 0);
        s[3] = model_ovf;
        s[12:8] = 5'(fifo_q.size());
        return s;
    endfunction

    task automatic csr_write(input logic [9:0] idx, input logic [31:0] data);
        @(negedge sys_clk);
        bus.csr_a  = {Page, idx};
        bus.csr_we = 1'b1;
        bus.csr_di = data;
        @(negedge sys_clk);
        bus.csr_we = 1'b0;
        bus.csr_di = '0;
        bus.csr_a  = '0;
    endtask

    task automatic csr_read(input logic [13:0] addr, output logic [31:0] data);
        @(negedge sys_clk);
        bus.csr_a  = addr;
        bus.csr_we = 1'b0;
        @(negedge sys_clk);
        data      = bus.csr_do;
        bus.csr_a = '0;
    endtask

    task automatic model_push(input logic [7:0] b);
        csr_write(10'd0, {24'h0, b});
        if (fifo_q.size() < 16) fifo_q.push_back(b);
        else model_ovf = 1'b1;
    endtask

    // Must be called right after the write that lets the first frame start.
    task automatic expect_frames(input int div, input int n, input int idle, output int busy_cnt);
        logic [7:0] b;
        logic       e;
        busy_cnt  = 0;
        bus.csr_a = {Page, 10'd2};
        for (int f = 0; f < n; f++) begin
            b = fifo_q.pop_front();
            for (int k = 0; k < 10 * div; k++) begin
                @(negedge sys_clk);
                if (k < div) e = 1'b0;
                else if (k >= 9 * div) e = 1'b1;
                else e = b[k/div-1];
                checks++;
                if (tx !== e) begin
                    errors++;
                    $display("FAIL frame_tx: frame %0d byte %h sample %0d got %b expected %b",
                             f, b, k, tx, e);
                end
                if (bus.csr_do[0] === 1'b1) busy_cnt++;
            end
        end
        for (int k = 0; k < idle; k++) begin
            @(negedge sys_clk);
            checks++;
            if (tx !== 1'b1) begin
                errors++;
                $display("FAIL idle_tx: sample %0d got %b expected 1", k, tx);
            end
            if (bus.csr_do[0] === 1'b1) busy_cnt++;
        end
        bus.csr_a = '0;
    endtask

    task automatic check_reg(input string name, input logic [13:0] addr,
                             input logic [31:0] exp);
        logic [31:0] d;
        csr_read(addr, d);
        checks++;
        if (d !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, d, exp);
        end
    endtask

    task automatic test_reset();
        bus.csr_a  = {Page, 10'd1};
        bus.csr_we = 1'b0;
        bus.csr_di = '0;
        repeat (3) @(negedge sys_clk);
        checks += 3;
        if (bus.csr_do !== 32'h0) begin
            errors++;
            $display("FAIL reset_csr_do: got %h expected 0", bus.csr_do);
        end
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx: got %b expected 1", tx);
        end
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b expected 0", irq);
        end
        sys_rst_n = 1'b1;
        check_reg("reset_divisor", {Page, 10'd1}, 32'h1B2);
        check_reg("reset_status", {Page, 10'd2}, 32'h4);
        check_reg("reset_ctrl", {Page, 10'd3}, 32'h0);
        check_reg("other_page", {4'h3, 10'd1}, 32'h0);
        check_reg("unmapped_idx", {Page, 10'd7}, 32'h0);
        check_reg("txdata_reads_zero", {Page, 10'd0}, 32'h0);
    endtask

    task automatic test_single_frame();
        int busy;
        csr_write(10'd1, 32'd4);
        csr_write(10'd3, 32'd1);
        model_push(8'hA5);
        expect_frames(4, 1, 3, busy);
        checks++;
        if (busy != 40) begin
            errors++;
            $display("FAIL single_busy_cycles: got %0d expected 40", busy);
        end
    endtask

    task automatic test_overflow_back_to_back();
        int busy;
        csr_write(10'd1, 32'd2);
        csr_write(10'd3, 32'd0);
        for (int i = 0; i < 17; i++) model_push(8'(i));
        check_reg("status_full_ovf", {Page, 10'd2}, exp_status());
        csr_write(10'd2, 32'h8);
        model_ovf = 1'b0;
        check_reg("status_ovf_cleared", {Page, 10'd2}, exp_status());
        csr_write(10'd3, 32'd1);
        expect_frames(2, 16, 4, busy);
        checks++;
        if (busy != 320) begin
            errors++;
            $display("FAIL b2b_busy_cycles: got %0d expected 320", busy);
        end
        check_reg("status_drained", {Page, 10'd2}, exp_status());
    endtask

    task automatic test_irq();
        logic [7:0] b;
        logic       e;
        csr_write(10'd1, 32'd8);
        csr_write(10'd3, 32'd3);
        repeat (2) @(negedge sys_clk);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_idle_empty: got %b expected 1", irq);
        end
        model_push(8'h55);
        b = fifo_q.pop_front();
        for (int k = 0; k < 86; k++) begin
            @(negedge sys_clk);
            checks += 2;
            if (irq !== (k >= 81)) begin
                errors++;
                $display("FAIL irq_timing: sample %0d got %b expected %b", k, irq, k >= 81);
            end
            if (k < 8) e = 1'b0;
            else if (k >= 72) e = 1'b1;
            else e = b[k/8-1];
            if (tx !== e) begin
                errors++;
                $display("FAIL irq_frame_tx: sample %0d got %b expected %b", k, tx, e);
            end
        end
        model_push(8'($urandom));
        @(negedge sys_clk);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_drop_on_push: got %b expected 0", irq);
        end
        repeat (90) @(negedge sys_clk);
        void'(fifo_q.pop_front());
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_after_second: got %b expected 1", irq);
        end
        csr_write(10'd3, 32'd0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) model_push(8'($urandom));
        check_reg("pre_flush_level", {Page, 10'd2}, exp_status());
        csr_write(10'd3, 32'd4);
        fifo_q.delete();
        check_reg("post_flush_status", {Page, 10'd2}, 32'h4);
        check_reg("flush_self_clear", {Page, 10'd3}, 32'h0);
        csr_write(10'd3, 32'd1);
        for (int k = 0; k < 20; k++) begin
            @(negedge sys_clk);
            checks++;
            if (tx !== 1'b1) begin
                errors++;
                $display("FAIL flush_no_frame: sample %0d got %b expected 1", k, tx);
            end
        end
        csr_write(10'd3, 32'd0);
        csr_write(10'd0, 32'h77);
        csr_write(10'd3, 32'd4);
        check_reg("push_then_flush", {Page, 10'd2}, 32'h4);
    endtask

    task automatic test_divisor_change();
        logic [7:0] b;
        logic       e;
        int         busy;
        b = 8'($urandom);
        csr_write(10'd1, 32'd10);
        csr_write(10'd3, 32'd1);
        csr_write(10'd0, {24'h0, b});
        for (int k = 0; k < 40; k++) begin
            @(negedge sys_clk);
            if (k < 10) e = 1'b0;
            else if (k < 34) e = b[(k-10)/3];
            else e = 1'b1;
            checks++;
            if (tx !== e) begin
                errors++;
                $display("FAIL div_change_tx: sample %0d got %b expected %b", k, tx, e);
            end
            if (k == 3) begin
                bus.csr_a  = {Page, 10'd1};
                bus.csr_we = 1'b1;
                bus.csr_di = 32'd3;
            end else if (k == 4) begin
                bus.csr_we = 1'b0;
                bus.csr_di = '0;
                bus.csr_a  = '0;
            end
        end
        csr_write(10'd1, 32'd0);
        model_push(8'($urandom));
        expect_frames(1, 1, 2, busy);
        checks++;
        if (busy != 10) begin
            errors++;
            $display("FAIL div0_busy_cycles: got %0d expected 10", busy);
        end
        csr_write(10'd3, 32'd0);
    endtask

    task automatic test_random();
        int d;
        int eff;
        int n;
        int busy;
        for (int r = 0; r < 5; r++) begin
            d   = $urandom_range(0, 6);
            eff = (d < 2) ? 1 : d;
            n   = $urandom_range(1, 4);
            csr_write(10'd1, 32'(d));
            check_reg("rand_divisor", {Page, 10'd1}, 32'(d));
            for (int i = 0; i < n; i++) model_push(8'($urandom));
            check_reg("rand_status", {Page, 10'd2}, exp_status());
            csr_write(10'd3, 32'd1);
            expect_frames(eff, n, 3, busy);
            checks++;
            if (busy != n * 10 * eff) begin
                errors++;
                $display("FAIL rand_busy_cycles: got %0d expected %0d", busy, n * 10 * eff);
            end
            csr_write(10'd3, 32'd0);
        end
    endtask

    task automatic test_reset_mid_frame();
        csr_write(10'd1, 32'd8);
        csr_write(10'd3, 32'd1);
        csr_write(10'd0, 32'h3C);
        repeat (4) @(negedge sys_clk);
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL mid_frame_start: got %b expected 0", tx);
        end
        #3 sys_rst_n = 1'b0;
        #1;
        checks += 2;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_tx: got %b expected 1", tx);
        end
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_irq: got %b expected 0", irq);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        fifo_q.delete();
        model_ovf = 1'b0;
        check_reg("rst_divisor", {Page, 10'd1}, 32'h1B2);
        check_reg("rst_status", {Page, 10'd2}, 32'h4);
        check_reg("rst_ctrl", {Page, 10'd3}, 32'h0);
    endtask

    initial begin
        bus.csr_a  = '0;
        bus.csr_we = 1'b0;
        bus.csr_di = '0;
        test_reset();
        test_single_frame();
        test_overflow_back_to_back();
        test_irq();
        test_flush();
        test_divisor_change();
        test_random();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/csr_serial_tx.md
Name: csr_serial_tx

Overview:
- CSR-bus responder peripheral that accepts bytes from the CPU through the CSR bridge and shifts them out on a physical serial line as 8N1 frames.
- Holds a small TX FIFO and a programmable baud divisor.
- Reports status and an interrupt back over the same CSR read path.
- Sits beside gpio, uart and sysctl on the CSR bus; its csr_do is OR-ed into the bridge's csr_di.

Parameters:
csr_addr, 4'h4, CSR page select; the block responds when csr_a[13:10] == csr_addr.
FIFO_DEPTH_LOG2, 4, TX FIFO depth = 2**FIFO_DEPTH_LOG2 entries (16).
DEFAULT_DIVISOR, 16'd434, reset value of DIVISOR (50 MHz / 115200 baud).

Ports:
sys_clk  in  1  system clock; all state on rising edge.
sys_rst_n  in  1  asynchronous, active-low reset.
csr_a  in  14  CSR address; [13:10] page, [9:0] register index.
csr_we  in  1  CSR write strobe, valid in the same cycle as csr_a/csr_di.
csr_di  in  32  CSR write data.
csr_do  out  32  CSR read data; registered; zero when not selected.
tx  out  1  serial output; idle high.
irq  out  1  level interrupt.

Behaviour:
- One clock (sys_clk); reset is asynchronous and active-low (sys_rst_n). All flops clear immediately on sys_rst_n low.
- Reset values:
  - csr_do = 0, tx = 1, irq = 0.
  - FIFO empty, DIVISOR = DEFAULT_DIVISOR.
  - CTRL = 0, overflow = 0, FSM IDLE.
- Select: sel = (csr_a[13:10] == csr_addr).
- Reads:
  - Each cycle, csr_do <= sel ? reg(csr_a[9:0]) : 0. One-cycle read latency; reads have no side effects.
  - Unmapped indices read 0.
- Register map (index = csr_a[9:0]):
  - 0 TXDATA: a write pushes csr_di[7:0] into the FIFO. If the FIFO is full, the byte is dropped and overflow is set. Reads return 0.
  - 1 DIVISOR:
    - [15:0] = cycles per bit; a value of 0 or 1 is treated as 1.
    - A write takes effect at the next bit boundary; the bit in flight keeps its old length.
  - 2 STATUS (read):
    - [0] busy = FSM not IDLE.
    - [1] full, [2] empty.
    - [3] overflow, sticky; writing 1 to bit 3 clears it.
    - [8+FIFO_DEPTH_LOG2:8] = FIFO level (0..depth).
  - 3 CTRL:
    - [0] tx_en: FSM only starts a frame when set.
    - [1] irq_en.
    - [2] flush: write-1 empties the FIFO in that cycle and self-clears; a frame already in the shifter completes.
- FIFO:
  - Synchronous, registered pointers of FIFO_DEPTH_LOG2+1 bits; wrap modulo depth.
  - Simultaneous push and pop in the same cycle: level unchanged, allowed even when full (pop frees the slot first).
  - Flush coincident with push: flush wins and the pushed byte is discarded.
- Transmit FSM states: IDLE, START, DATA, STOP.
  - Bit counter: 16-bit, reloaded with eff_div-1 at each bit start; the bit ends when the counter reaches 0.
  - IDLE: tx = 1. If tx_en and not empty, pop the FIFO head into an 8-bit shift register and go to START the next cycle.
  - START: tx = 0 for one bit time, then go to DATA.
  - DATA: send 8 bits LSB first, each for one bit time, using a 3-bit index; after bit 7 go to STOP.
  - STOP: tx = 1 for one bit time. At the end:
    - If tx_en and not empty, pop and go directly to START (back-to-back frames, no idle gap).
    - Otherwise go to IDLE.
  - Clearing tx_en mid-frame does not abort the current frame; it only prevents the next one from starting.
- Frame length = 10 × eff_div cycles. First start-bit edge appears 2 cycles after the TXDATA write when IDLE with tx_en set (push cycle, pop cycle).
- irq = irq_en & empty & ~busy, registered (one-cycle lag). irq is level-sensitive and clears when new data is pushed.
- Reset mid-frame: tx returns high asynchronously; the frame is lost.

Test Plan:
- Reset, then read idx 1/2/3 at page 4 → DIVISOR = 0x1B2; STATUS = 0x4 (empty); CTRL = 0; tx = 1; reads at page 3 → csr_do = 0.
- DIVISOR=4, CTRL=1, write TXDATA 0xA5 → tx: start 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 each 4 cycles, stop 1 for 4 cycles; busy = 1 for 40 cycles.
- DIVISOR=2, CTRL=0:
  - Push 17 bytes 0x00..0x10 → STATUS full = 1, level = 16, overflow = 1.
  - Write STATUS 0x8 → overflow = 0.
  - Set CTRL=1 → 16 frames 0x00..0x0F back-to-back, no idle between the stop and the next start; 0x10 never sent.
- DIVISOR=8, CTRL=3, push 0x55, wait for frame end → irq rises 1 cycle after busy falls; push another byte → irq drops.
- Push 3 bytes with CTRL=0, then write CTRL=4 → level = 0, empty = 1, no frames sent; flush coincident with a push → level stays 0.
- DIVISOR=10 mid-frame, write DIVISOR=3 → current bit keeps 10 cycles, following bits 3 cycles; DIVISOR=0 → 1-cycle bits.
